sra_ctrl: RTL



---
 rtl/sra_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sra_ctrl.sv
// Control unit for the 16-bit square-root-approximation datapath.
// It walks the datapath through one SRA = max(0.875*x + 0.5*y, x) evaluation.
module sra_ctrl #(
   parameter int CW = 21
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          r1_neg,
   input  logic          r2_neg,
   input  logic          r1_lt_r2,
   input  logic          au2_neg,
   output logic [CW-1:0] ctrl_word,
   output logic          busy,
   output logic          done
);

   localparam logic [1:0] AU1_PASSA = 2'b00;
   localparam logic [1:0] AU1_PASSB = 2'b01;
   localparam logic [1:0] AU1_NEGA  = 2'b10;
   localparam logic [1:0] AU1_NEGB  = 2'b11;
   localparam logic [1:0] AU2_ADD   = 2'b00;
   localparam logic [1:0] AU2_SUB   = 2'b01;
   localparam logic [1:0] AU2_PASSA = 2'b10;

   localparam int W_R5    = 20;
   localparam int W_R4    = 19;
   localparam int W_R3    = 18;
   localparam int W_R2    = 17;
   localparam int W_R1    = 16;
   localparam int S0_R1   = 15;
   localparam int S1_R1   = 14;
   localparam int S0_R2   = 13;
   localparam int S1_R2   = 12;
   localparam int S1_BAU1 = 10;
   localparam int S0_R5   = 9;
   localparam int S1_R5   = 8;
   localparam int S0_AAU2 = 7;
   localparam int S1_AAU2 = 6;
   localparam int O_EN    = 1;

   typedef enum logic [3:0] {
      S_IDLE, S_LOAD, S_ABS_A, S_ABS_B, S_SEL_X, S_SEL_Y,
      S_SH_X, S_SUB, S_ADD, S_CMP, S_MAX, S_OUT
   } state_t;

   state_t state, next_state;
   logic   lt_q;
   logic   x_gt_q;

   // Handshake: start is sampled only in IDLE (no queuing while busy); done
   // pulses for the single OUT cycle, while the datapath drives the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         lt_q   <= 1'b0;
         x_gt_q <= 1'b0;
      end else begin
         state <= next_state;
         if (state == S_SEL_X) lt_q   <= r1_lt_r2;
         if (state == S_CMP)   x_gt_q <= ~au2_neg;
      end
   end

   always_comb begin
      next_state = state;
      ctrl_word  = '0;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      case (state)
         S_IDLE:  if (start) next_state = S_LOAD;
         S_LOAD: begin
            ctrl_word[S0_R1] = 1'b1;
            ctrl_word[S0_R2] = 1'b1;
            ctrl_word[W_R1]  = 1'b1;
            ctrl_word[W_R2]  = 1'b1;
            next_state       = S_ABS_A;
         end
         S_ABS_A: begin
            ctrl_word[3:2]   = AU1_NEGA;
            ctrl_word[S1_R1] = 1'b1;
            ctrl_word[W_R1]  = r1_neg;
            next_state       = S_ABS_B;
         end
         S_ABS_B: begin
            ctrl_word[S1_BAU1] = 1'b1;
            ctrl_word[3:2]     = AU1_NEGB;
            ctrl_word[S1_R2]   = 1'b1;
            ctrl_word[W_R2]    = r2_neg;
            next_state         = S_SEL_X;
         end
         S_SEL_X: begin
            ctrl_word[S1_BAU1] = 1'b1;
            ctrl_word[W_R4]    = 1'b1;
            ctrl_word[3:2]     = r1_lt_r2 ? AU1_PASSB : AU1_PASSA;
            next_state         = S_SEL_Y;
         end
         S_SEL_Y: begin
            ctrl_word[S1_BAU1] = 1'b1;
            ctrl_word[W_R3]    = 1'b1;
            ctrl_word[3:2]     = lt_q ? AU1_PASSA : AU1_PASSB;
            next_state         = S_SH_X;
         end
         S_SH_X: begin
            ctrl_word[S1_BAU1] = 1'b1;
            ctrl_word[S0_R5]   = 1'b1;
            ctrl_word[W_R5]    = 1'b1;
            ctrl_word[3:2]     = lt_q ? AU1_PASSB : AU1_PASSA;
            next_state         = S_SUB;
         end
         S_SUB: begin
            ctrl_word[S0_AAU2] = 1'b1;
            ctrl_word[5:4]     = AU2_SUB;
            ctrl_word[S1_R5]   = 1'b1;
            ctrl_word[W_R5]    = 1'b1;
            next_state         = S_ADD;
         end
         S_ADD: begin
            ctrl_word[S1_AAU2] = 1'b1;
            ctrl_word[5:4]     = AU2_ADD;
            ctrl_word[S1_R5]   = 1'b1;
            ctrl_word[W_R5]    = 1'b1;
            next_state         = S_CMP;
         end
         S_CMP: begin
            ctrl_word[S0_AAU2] = 1'b1;
            ctrl_word[5:4]     = AU2_SUB;
            next_state         = S_MAX;
         end
         S_MAX: begin
            ctrl_word[S0_AAU2] = 1'b1;
            ctrl_word[5:4]     = AU2_PASSA;
            ctrl_word[S1_R5]   = 1'b1;
            ctrl_word[W_R5]    = x_gt_q;
            next_state         = S_OUT;
         end
         S_OUT: begin
            ctrl_word[O_EN] = 1'b1;
            done            = 1'b1;
            next_state      = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
   end

endmodule
